// File: rtl/sram_arb_pkg.sv
// Shared definitions for the SRAM port arbiter: access encoding, parameter
// limits and the channel-id width helper.
package sram_arb_pkg;

    localparam int NUM_CH_MIN = 1;
    localparam int NUM_CH_MAX = 8;
    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 4;

    typedef enum logic {
        ACC_RD = 1'b0,
        ACC_WR = 1'b1
    } acc_e;

    // A single channel still needs a 1-bit id so vectors never collapse to zero width.
    function automatic int ch_id_w(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/sram_port_arbiter_if.sv
// Request/grant/read-return bundle between the requesting channels and the
// SRAM port arbiter; channel i occupies slice i of the packed buses.
interface sram_port_arbiter_if #(
    parameter int NUM_CH     = 2,
    parameter int ADDR_WIDTH = 20,
    parameter int DATA_WIDTH = 32
);
    logic [NUM_CH-1:0]            ch_req;
    logic [NUM_CH-1:0]            ch_wr;
    logic [NUM_CH*ADDR_WIDTH-1:0] ch_addr;
    logic [NUM_CH*DATA_WIDTH-1:0] ch_wr_data;
    logic [NUM_CH-1:0]            ch_gnt;
    logic [NUM_CH-1:0]            ch_rd_valid;
    logic [DATA_WIDTH-1:0]        ch_rd_data;

    modport master (
        output ch_req, ch_wr, ch_addr, ch_wr_data,
        input  ch_gnt, ch_rd_valid, ch_rd_data
    );

    modport slave (
        input  ch_req, ch_wr, ch_addr, ch_wr_data,
        output ch_gnt, ch_rd_valid, ch_rd_data
    );
endinterface

// File: rtl/sram_port_arbiter_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, search starting one past
// the last accepted winner.
module rr_arbiter
    import sram_arb_pkg::*;
#(
    parameter int NUM_CH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] req_i,
    input  logic              accept_i,
    output logic [NUM_CH-1:0] gnt_o
);
    localparam int IDW = ch_id_w(NUM_CH);
    localparam logic [IDW-1:0] PTR_RST = IDW'(NUM_CH - 1);

    logic [IDW-1:0] ptr_q;
    logic [IDW-1:0] ptr_d;
    logic [IDW-1:0] cand;

    // Walk from the farthest offset down so the nearest eligible channel wins last.
    always_comb begin
        gnt_o = '0;
        ptr_d = ptr_q;
        cand  = '0;
        for (int off = NUM_CH; off >= 1; off--) begin
            cand = IDW'((int'(ptr_q) + off) % NUM_CH);
            if (req_i[cand]) begin
                gnt_o = NUM_CH'(1) << cand;
                ptr_d = cand;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= PTR_RST;
        end else if (accept_i) begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Multi-channel front end for the shared single-port SRAM: round-robin grant,
// registered SRAM command, and tagged read-data return to the issuing channel.
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 20,
    parameter int NUM_CH     = 2,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  boot_mode,
    sram_port_arbiter_if.slave    ch_bus,
    output logic                  sram_mem_wr_en,
    output logic                  sram_mem_rd_en,
    output logic [ADDR_WIDTH-1:0] sram_mem_addr,
    output logic [DATA_WIDTH-1:0] sram_mem_wr_data,
    input  logic [DATA_WIDTH-1:0] sram_mem_rd_data
);
    localparam int IDW = ch_id_w(NUM_CH);

    if (NUM_CH < NUM_CH_MIN || NUM_CH > NUM_CH_MAX ||
        RD_LATENCY < RD_LAT_MIN || RD_LATENCY > RD_LAT_MAX) begin : g_bad_param
        $error("sram_port_arbiter: NUM_CH or RD_LATENCY out of range");
    end

    logic [NUM_CH-1:0]     elig;
    logic [NUM_CH-1:0]     gnt;
    logic                  accept;
    acc_e                  sel_acc;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_data;
    logic [IDW-1:0]        sel_id;

    logic                  wr_en_q, rd_en_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wr_data_q;
    logic [RD_LATENCY:0]   tag_vld_q;
    logic [IDW-1:0]        tag_id_q [0:RD_LATENCY];
    logic [NUM_CH-1:0]     rd_valid_q;
    logic [DATA_WIDTH-1:0] rd_data_q;

    // In boot mode only the bootloader (channel 0) may compete.
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_elig
        assign elig[gi] = ch_bus.ch_req[gi] & (~boot_mode | (gi == 0));
    end

    rr_arbiter #(.NUM_CH(NUM_CH)) u_rr (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_i    (elig),
        .accept_i (accept),
        .gnt_o    (gnt)
    );

    assign accept        = |(ch_bus.ch_req & gnt);
    assign ch_bus.ch_gnt = gnt;

    always_comb begin
        sel_acc  = ACC_RD;
        sel_addr = '0;
        sel_data = '0;
        sel_id   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (gnt[i]) begin
                sel_acc  = acc_e'(ch_bus.ch_wr[i]);
                sel_addr = ch_bus.ch_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_data = ch_bus.ch_wr_data[i*DATA_WIDTH +: DATA_WIDTH];
                sel_id   = IDW'(i);
            end
        end
    end

    // Address and write data deliberately hold when idle; only the strobes drop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en_q   <= 1'b0;
            rd_en_q   <= 1'b0;
            addr_q    <= '0;
            wr_data_q <= '0;
        end else begin
            wr_en_q <= accept & (sel_acc == ACC_WR);
            rd_en_q <= accept & (sel_acc == ACC_RD);
            if (accept) begin
                addr_q    <= sel_addr;
                wr_data_q <= sel_data;
            end
        end
    end

    // Stage 0 lines up with rd_en; stage RD_LATENCY with valid SRAM read data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_vld_q <= '0;
            for (int k = 0; k <= RD_LATENCY; k++) begin
                tag_id_q[k] <= '0;
            end
        end else begin
            tag_vld_q[0] <= accept & (sel_acc == ACC_RD);
            tag_id_q[0]  <= sel_id;
            for (int k = 1; k <= RD_LATENCY; k++) begin
                tag_vld_q[k] <= tag_vld_q[k-1];
                tag_id_q[k]  <= tag_id_q[k-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_q <= '0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= tag_vld_q[RD_LATENCY] ? (NUM_CH'(1) << tag_id_q[RD_LATENCY]) : '0;
            if (tag_vld_q[RD_LATENCY]) begin
                rd_data_q <= sram_mem_rd_data;
            end
        end
    end

    assign sram_mem_wr_en     = wr_en_q;
    assign sram_mem_rd_en     = rd_en_q;
    assign sram_mem_addr      = addr_q;
    assign sram_mem_wr_data   = wr_data_q;
    assign ch_bus.ch_rd_valid = rd_valid_q;
    assign ch_bus.ch_rd_data  = rd_data_q;

endmodule
